// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: PC selection (redirect > predicted >
//            PC+4), single-outstanding imem requests and a response FIFO
//            drained by decode. Optional macro FETCH_PERF_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] pc_if,
   input  logic        predict_taken,
   input  logic [31:0] predict_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);

   localparam int             PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]    ALIGN    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      tag_pc_q;
   logic             tag_pt_q;
   logic [31:0]      tag_tgt_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   cnt_q;

   logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]      fifo_instr_q [FIFO_DEPTH];
   logic             fifo_pt_q    [FIFO_DEPTH];
   logic [31:0]      fifo_tgt_q   [FIFO_DEPTH];

   logic             req, issue, push, pop, drop;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req     = 1'b0;
      issue   = 1'b0;
      push    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Issue only when a FIFO slot is free, so the response always fits.
            req   = rst_n && (cnt_q != FULL_CNT) && !redirect_valid;
            issue = req && imem_gnt;
            if (issue) begin
               state_d = S_WAIT;
               pc_d    = predict_taken ? (predict_target & ALIGN) : pc_q + 32'd4;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               state_d = S_DROP;
               drop    = imem_rvalid;
            end else if (imem_rvalid) begin
               state_d = S_IDLE;
               push    = 1'b1;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               state_d = S_IDLE;
               drop    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (redirect_valid) begin
         pc_d = redirect_pc & ALIGN;
      end
      pop = (cnt_q != '0) && if_ready && !redirect_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         tag_pc_q  <= '0;
         tag_pt_q  <= 1'b0;
         tag_tgt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
            fifo_pt_q[i]    <= 1'b0;
            fifo_tgt_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (issue) begin
            tag_pc_q  <= pc_q;
            tag_pt_q  <= predict_taken;
            tag_tgt_q <= predict_target;
         end
         if (push) begin
            fifo_pc_q[wr_ptr_q]    <= tag_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pt_q[wr_ptr_q]    <= tag_pt_q;
            fifo_tgt_q[wr_ptr_q]   <= tag_tgt_q;
         end
         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

   assign pc_if          = pc_q;
   assign imem_addr      = pc_q;
   assign imem_req       = req;
   assign if_valid       = (cnt_q != '0);
   assign if_pc          = fifo_pc_q[rd_ptr_q];
   assign if_instr       = fifo_instr_q[rd_ptr_q];
   assign if_pred_taken  = fifo_pt_q[rd_ptr_q];
   assign if_pred_target = fifo_tgt_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_dropped_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_dropped_q <= '0;
      end else begin
         if (pop)  perf_fetched_q <= perf_fetched_q + 32'd1;
         if (drop) perf_dropped_q <= perf_dropped_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_dropped = perf_dropped_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Cycle-table bench for fetch_unit (1-cycle memory, redirects,
//            backpressure, async reset). Checks perf counters if FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_if;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_if          (pc_if),
      .predict_taken  (predict_taken),
      .predict_target (predict_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_dropped   (perf_dropped)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        gnt, rv;
      logic [31:0] rdata;
      logic        rdy, pt;
      logic [31:0] ptgt;
      logic        rd;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc, e_instr;
      logic        e_pt;
      logic [31:0] e_tgt;
      int          e_pf, e_pd;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic gnt, rv, input logic [31:0] rdata, input logic rdy, pt,
      input logic [31:0] ptgt, input logic rd, input logic [31:0] rpc,
      input logic e_req, input logic [31:0] e_addr, input logic e_v,
      input logic [31:0] e_pc, e_instr, input logic e_pt, input logic [31:0] e_tgt,
      input int e_pf, e_pd);
      vec_t v;
      v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.pt = pt;
      v.ptgt = ptgt; v.rd = rd; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
      v.e_v = e_v; v.e_pc = e_pc; v.e_instr = e_instr; v.e_pt = e_pt;
      v.e_tgt = e_tgt; v.e_pf = e_pf; v.e_pd = e_pd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      imem_gnt       = v.gnt;
      imem_rvalid    = v.rv;
      imem_rdata     = v.rdata;
      if_ready       = v.rdy;
      predict_taken  = v.pt;
      predict_target = v.ptgt;
      redirect_valid = v.rd;
      redirect_pc    = v.rpc;
   endtask

   initial begin
      // gnt rv rdata rdy pt ptgt rd rpc | req addr v pc instr pt tgt | pf pd
      vecs[0]  = mk(1,0,0,           1,0,0,     0,0,     1,32'h000,0,0,0,0,0,                       0,0);
      vecs[1]  = mk(0,1,32'hC0000000,1,0,0,     0,0,     0,32'h004,0,0,0,0,0,                       0,0);
      vecs[2]  = mk(1,0,0,           1,0,0,     0,0,     1,32'h004,1,32'h000,32'hC0000000,0,0,      0,0);
      vecs[3]  = mk(0,1,32'hC0000004,1,0,0,     0,0,     0,32'h008,0,0,0,0,0,                       1,0);
      vecs[4]  = mk(1,0,0,           1,1,32'h100,0,0,    1,32'h008,1,32'h004,32'hC0000004,0,0,      1,0);
      vecs[5]  = mk(0,1,32'hC0000008,1,0,0,     0,0,     0,32'h100,0,0,0,0,0,                       2,0);
      vecs[6]  = mk(1,0,0,           0,0,0,     0,0,     1,32'h100,1,32'h008,32'hC0000008,1,32'h100,2,0);
      vecs[7]  = mk(0,1,32'hC0000100,0,0,0,     0,0,     0,32'h104,1,32'h008,32'hC0000008,1,32'h100,2,0);
      vecs[8]  = mk(1,0,0,           0,0,0,     0,0,     0,32'h104,1,32'h008,32'hC0000008,1,32'h100,2,0);
      vecs[9]  = mk(1,0,0,           0,0,0,     0,0,     0,32'h104,1,32'h008,32'hC0000008,1,32'h100,2,0);
      vecs[10] = mk(0,0,0,           1,0,0,     0,0,     0,32'h104,1,32'h008,32'hC0000008,1,32'h100,2,0);
      vecs[11] = mk(1,0,0,           0,0,0,     0,0,     1,32'h104,1,32'h100,32'hC0000100,0,0,      3,0);
      vecs[12] = mk(0,0,0,           0,0,0,     1,32'h203,0,32'h108,1,32'h100,32'hC0000100,0,0,     3,0);
      vecs[13] = mk(0,0,0,           0,0,0,     0,0,     0,32'h200,0,0,0,0,0,                       3,0);
      vecs[14] = mk(0,1,32'hDEADBEEF,0,0,0,     0,0,     0,32'h200,0,0,0,0,0,                       3,0);
      vecs[15] = mk(1,0,0,           1,0,0,     0,0,     1,32'h200,0,0,0,0,0,                       3,1);
      vecs[16] = mk(0,1,32'hC0000200,1,0,0,     0,0,     0,32'h204,0,0,0,0,0,                       3,1);
      vecs[17] = mk(0,0,0,           0,0,0,     0,0,     1,32'h204,1,32'h200,32'hC0000200,0,0,      3,1);
      vecs[18] = mk(1,1,32'h11111111,1,0,0,     1,32'h300,0,32'h204,1,32'h200,32'hC0000200,0,0,     3,1);
      vecs[19] = mk(1,0,0,           1,0,0,     0,0,     1,32'h300,0,0,0,0,0,                       3,1);
      vecs[20] = mk(0,1,32'hC0000300,1,0,0,     0,0,     0,32'h304,0,0,0,0,0,                       3,1);
      vecs[21] = mk(0,0,0,           1,0,0,     0,0,     1,32'h304,1,32'h300,32'hC0000300,0,0,      3,1);
      vecs[22] = mk(0,0,0,           1,0,0,     0,0,     1,32'h304,0,0,0,0,0,                       4,1);
      vecs[23] = mk(1,0,0,           1,0,0,     0,0,     1,32'h304,0,0,0,0,0,                       4,1);
      vecs[24] = mk(0,1,32'h22222222,1,0,0,     1,32'h400,0,32'h308,0,0,0,0,0,                      4,1);
      vecs[25] = mk(1,0,0,           1,0,0,     0,0,     0,32'h400,0,0,0,0,0,                       4,2);
      vecs[26] = mk(0,1,32'h33333333,1,0,0,     0,0,     0,32'h400,0,0,0,0,0,                       4,2);
      vecs[27] = mk(1,0,0,           1,0,0,     0,0,     1,32'h400,0,0,0,0,0,                       4,3);

      rst_n = 1'b0;
      drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0));
      #3;
      chk("reset imem_req",       {31'd0, imem_req},      32'd0);
      chk("reset imem_addr",      imem_addr,              32'd0);
      chk("reset pc_if",          pc_if,                  32'd0);
      chk("reset if_valid",       {31'd0, if_valid},      32'd0);
      chk("reset if_pc",          if_pc,                  32'd0);
      chk("reset if_instr",       if_instr,               32'd0);
      chk("reset if_pred_taken",  {31'd0, if_pred_taken}, 32'd0);
      chk("reset if_pred_target", if_pred_target,         32'd0);
`ifdef FETCH_PERF_EN
      chk("reset perf_fetched",   perf_fetched,           32'd0);
      chk("reset perf_dropped",   perf_dropped,           32'd0);
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         #2;
         chk($sformatf("c%0d imem_req", i),  {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         chk($sformatf("c%0d imem_addr", i), imem_addr,         vecs[i].e_addr);
         chk($sformatf("c%0d pc_if", i),     pc_if,             vecs[i].e_addr);
         chk($sformatf("c%0d if_valid", i),  {31'd0, if_valid}, {31'd0, vecs[i].e_v});
         if (vecs[i].e_v) begin
            chk($sformatf("c%0d if_pc", i),          if_pc,                  vecs[i].e_pc);
            chk($sformatf("c%0d if_instr", i),       if_instr,               vecs[i].e_instr);
            chk($sformatf("c%0d if_pred_taken", i),  {31'd0, if_pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("c%0d if_pred_target", i), if_pred_target,         vecs[i].e_tgt);
         end
`ifdef FETCH_PERF_EN
         chk($sformatf("c%0d perf_fetched", i), perf_fetched, 32'(vecs[i].e_pf));
         chk($sformatf("c%0d perf_dropped", i), perf_dropped, 32'(vecs[i].e_pd));
`endif
         @(posedge clk);
         #1;
      end

      // Asynchronous reset mid-transaction (request to 0x400 in flight).
      drive(mk(1,0,0,1,0,0,0,0, 0,0,0,0,0,0,0, 0,0));
      #2;
      chk("pre-reset imem_addr", imem_addr, 32'h404);
      rst_n = 1'b0;
      #1;
      chk("async reset imem_addr", imem_addr,         32'd0);
      chk("async reset imem_req",  {31'd0, imem_req}, 32'd0);
      chk("async reset if_valid",  {31'd0, if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
      chk("async reset perf_fetched", perf_fetched, 32'd0);
      chk("async reset perf_dropped", perf_dropped, 32'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      chk("post-reset imem_req",  {31'd0, imem_req}, 32'd1);
      chk("post-reset imem_addr", imem_addr,         32'd0);
      @(posedge clk);
      #2;
      chk("post-reset next addr", imem_addr, 32'h004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the fetch PC. Each cycle it presents the PC to the branch predictor and selects the next PC with priority: EX redirect, then predicted target, then PC+4. It issues single-outstanding requests to instruction memory and buffers responses with their prediction metadata in a small FIFO. Decode drains the FIFO through a valid/ready handshake.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_if  out  32  current fetch PC, to predictor lookup
predict_taken  in  1  predictor hit and taken for pc_if (same cycle)
predict_target  in  32  predicted target for pc_if
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
redirect_valid  in  1  EX mispredict or exception redirect
redirect_pc  in  32  redirect address
if_valid  out  1  head entry valid toward decode
if_ready  in  1  decode accepts head entry
if_pc  out  32  PC of head instruction
if_instr  out  32  head instruction
if_pred_taken  out  1  prediction used for head
if_pred_target  out  32  predicted target for head

Behaviour:
- Reset (async, rst_n=0): pc_reg=RESET_PC, state IDLE, FIFO empty. imem_req=0, if_valid=0, if_pc/if_instr/if_pred_target=0, if_pred_taken=0.
- pc_if = imem_addr = pc_reg. Bits [1:0] are always 0, and redirect_pc[1:0] is forced to 0.
- FSM states:
  - IDLE: imem_req = (count < FIFO_DEPTH) && !redirect_valid. On req&&gnt, latch {pc_reg, predict_taken, predict_target} as in-flight tag. Set pc_reg <= predict_taken ? predict_target : pc_reg+4 (mod 2^32). Go to WAIT.
  - WAIT: imem_req=0. On rvalid, push {tag pc, rdata, tag pred} and go to IDLE. Request throughput is at most one per 2 cycles.
  - DROP: imem_req=0. On rvalid, discard the data and go to IDLE.
- The FIFO slot is reserved at issue, since issue requires count < FIFO_DEPTH and only one request is in flight. A push can never overflow, and push plus pop in the same cycle is legal at any occupancy.
- Decode side:
  - if_valid = count != 0. Head fields are driven from registered storage.
  - Pop occurs on if_valid && if_ready. Pointers wrap modulo FIFO_DEPTH.
- Redirect has the highest priority and overrides every other event:
  - pc_reg <= redirect_pc.
  - FIFO is flushed, so if_valid=0 next cycle, and any pop in that cycle is ignored.
  - In IDLE, no request is issued that cycle.
  - In WAIT, go to DROP, even if rvalid arrives in the same cycle; that data is discarded.
  - In DROP, stay in DROP unless rvalid arrives in the same cycle, in which case go to IDLE.
- rvalid in IDLE is spurious and is ignored.
- gnt without req is ignored.
- Latency, with 1-cycle memory: req&gnt at cycle N, rvalid at N+1, if_valid at N+2.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_dropped (32), both reset to 0.
  - perf_fetched increments on every pop.
  - perf_dropped increments on every rvalid discarded in DROP, or in WAIT when it coincides with a redirect.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory returns 1-cycle responses, if_ready=1, predict_taken=0 -> imem_addr 0x0,0x4,0x8 on successive issues; if_pc 0x0 appears 2 cycles after first gnt, with if_pred_taken=0.
- predict_taken=1, target 0x100 while pc_if=0x8 -> next imem_addr=0x100; if_pc=0x8 entry carries if_pred_taken=1, if_pred_target=0x100.
- if_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries fill and imem_req stays 0; one pop -> imem_req reasserts the next cycle.
- redirect_valid with redirect_pc=0x203 while in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word discarded, FIFO empty, next imem_addr=0x200, first delivered if_pc=0x200.
- redirect in the same cycle as rvalid and an if_ready pop with 1 entry queued -> nothing delivered, FIFO empty, next fetch at redirect_pc.
- With FETCH_PERF_EN: run the sequence of the fourth scenario -> perf_dropped=1 and perf_fetched equals the number of pops observed.
